// File: rtl/buzzer_mc.sv
// Multi-channel beep sequencer with per-channel tone divider and a fixed-priority pin arbiter.
// Latency: ch_active follows the sampling edge combinationally from state; BUZZER_OUT lags by one cycle.
// No backpressure: enable is a level request, and channels that lose arbitration keep sequencing silently.
module buzzer_mc #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 32,
  parameter int TONE_W   = 16,
  parameter int BURST_W  = 8,
  localparam int GW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [CHANNELS-1:0]         enable,
  input  logic [2*CHANNELS-1:0]       mode,
  input  logic [CNT_W*CHANNELS-1:0]   duration_on,
  input  logic [CNT_W*CHANNELS-1:0]   duration_off,
  input  logic [TONE_W*CHANNELS-1:0]  tone_div,
  input  logic [BURST_W*CHANNELS-1:0] burst_count,
  output logic [CHANNELS-1:0]         ch_active,
  output logic [CHANNELS-1:0]         ch_done,
  output logic                        buzzer_active,
  output logic [GW-1:0]               grant_idx,
  output logic                        BUZZER_OUT
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_HOLD} state_t;

  localparam logic [1:0] M_SINGLE   = 2'b00;
  localparam logic [1:0] M_PERIODIC = 2'b01;
  localparam logic [1:0] M_CONT     = 2'b10;

  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  logic [CHANNELS-1:0] tone_bit;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t               state_q, state_d;
    logic [1:0]           mode_q;
    logic [CNT_W-1:0]     don_q, doff_q, cnt_q, don_in, doff_in;
    logic [TONE_W-1:0]    div_q, tcnt_q;
    logic [BURST_W-1:0]   bc_q, nb_in;
    logic                 phase_q, done_q;
    logic                 en, start, cnt_zero, enter_on, enter_off;

    assign en       = enable[i];
    assign start    = (state_q == S_IDLE) && en;
    assign cnt_zero = (cnt_q == '0);
    // Zero-length durations and burst counts are promoted to 1 at snapshot time.
    assign don_in   = (duration_on[CNT_W*i +: CNT_W] == '0) ? CNT_ONE : duration_on[CNT_W*i +: CNT_W];
    assign doff_in  = (duration_off[CNT_W*i +: CNT_W] == '0) ? CNT_ONE : duration_off[CNT_W*i +: CNT_W];
    assign nb_in    = (burst_count[BURST_W*i +: BURST_W] == '0) ? BURST_ONE : burst_count[BURST_W*i +: BURST_W];

    // Next-state decode; enter_on/enter_off tell the datapath which duration to load.
    always_comb begin
      state_d   = state_q;
      enter_on  = 1'b0;
      enter_off = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (en) begin
            state_d  = S_ON;
            enter_on = 1'b1;
          end
        end
        S_ON: begin
          case (mode_q)
            M_SINGLE: begin
              if (cnt_zero) state_d = S_HOLD;
            end
            M_PERIODIC: begin
              if (cnt_zero) begin
                state_d   = S_OFF;
                enter_off = 1'b1;
              end
            end
            M_CONT: begin
              if (!en) state_d = S_IDLE;
            end
            default: begin
              if (!en) begin
                state_d = S_IDLE;
              end else if (cnt_zero) begin
                state_d   = S_OFF;
                enter_off = 1'b1;
              end
            end
          endcase
        end
        S_OFF: begin
          if (mode_q == M_PERIODIC) begin
            // Enable is only looked at once the OFF half of the pair is complete.
            if (cnt_zero) begin
              if (en) begin
                state_d  = S_ON;
                enter_on = 1'b1;
              end else begin
                state_d = S_IDLE;
              end
            end
          end else begin
            if (!en) begin
              state_d = S_IDLE;
            end else if (cnt_zero) begin
              if (bc_q == '0) begin
                state_d = S_HOLD;
              end else begin
                state_d  = S_ON;
                enter_on = 1'b1;
              end
            end
          end
        end
        default: begin
          if (!en) state_d = S_IDLE;
        end
      endcase
    end

    // State register.
    always_ff @(posedge clk) begin
      if (!resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
    end

    // Config snapshot, duration/burst counters, tone divider and done pulse.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        mode_q  <= '0;
        don_q   <= '0;
        doff_q  <= '0;
        div_q   <= '0;
        cnt_q   <= '0;
        tcnt_q  <= '0;
        bc_q    <= '0;
        phase_q <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        done_q <= (state_d == S_HOLD) && (state_q != S_HOLD);
        if (start) begin
          mode_q <= mode[2*i +: 2];
          don_q  <= don_in;
          doff_q <= doff_in;
          div_q  <= tone_div[TONE_W*i +: TONE_W];
        end
        if (start)                  cnt_q <= don_in - CNT_ONE;
        else if (enter_on)          cnt_q <= don_q - CNT_ONE;
        else if (enter_off)         cnt_q <= doff_q - CNT_ONE;
        else if (!cnt_zero)         cnt_q <= cnt_q - CNT_ONE;
        if (start)                  bc_q  <= nb_in;
        else if (enter_off && mode_q != M_PERIODIC) bc_q <= bc_q - BURST_ONE;
        if (enter_on) begin
          tcnt_q  <= '0;
          phase_q <= 1'b1;
        end else if (state_q == S_ON && div_q != '0) begin
          if (tcnt_q == div_q) begin
            tcnt_q  <= '0;
            phase_q <= ~phase_q;
          end else begin
            tcnt_q <= tcnt_q + TONE_W'(1);
          end
        end
      end
    end

    assign ch_active[i] = (state_q == S_ON);
    assign ch_done[i]   = done_q;
    assign tone_bit[i]  = (state_q == S_ON) && ((div_q == '0) || phase_q);
  end

  logic          win_tone;
  logic [GW-1:0] win_idx;

  // Lowest-index ON channel owns the pin; scanning downward leaves the lowest hit last.
  always_comb begin
    win_tone = 1'b0;
    win_idx  = '0;
    for (int j = CHANNELS - 1; j >= 0; j--) begin
      if (ch_active[j]) begin
        win_tone = tone_bit[j];
        win_idx  = GW'(j);
      end
    end
  end

  assign grant_idx     = win_idx;
  assign buzzer_active = |ch_active;

  // Registered pin drive.
  always_ff @(posedge clk) begin
    if (!resetn) BUZZER_OUT <= 1'b0;
    else         BUZZER_OUT <= win_tone;
  end

endmodule

// File: tb/tb_buzzer_mc.sv
// Scoreboard bench for buzzer_mc: stimulus tables per scenario, interval-based reference model,
// expected outputs queued by the driver and popped by an independent monitor.
// Scenarios 0-5 are directed, the rest are randomized.
module tb_buzzer_mc;
  localparam int CH = 4, CNT_W = 32, TONE_W = 16, BURST_W = 8;
  localparam int N = 300, NSCEN = 16;

  logic                 clk = 1'b1;
  logic                 resetn;
  logic [CH-1:0]        enable;
  logic [2*CH-1:0]      mode;
  logic [CNT_W*CH-1:0]  duration_on, duration_off;
  logic [TONE_W*CH-1:0] tone_div;
  logic [BURST_W*CH-1:0] burst_count;
  logic [CH-1:0]        ch_active, ch_done;
  logic                 buzzer_active;
  logic [1:0]           grant_idx;
  logic                 BUZZER_OUT;

  buzzer_mc #(.CHANNELS(CH), .CNT_W(CNT_W), .TONE_W(TONE_W), .BURST_W(BURST_W)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .mode(mode),
    .duration_on(duration_on), .duration_off(duration_off), .tone_div(tone_div),
    .burst_count(burst_count), .ch_active(ch_active), .ch_done(ch_done),
    .buzzer_active(buzzer_active), .grant_idx(grant_idx), .BUZZER_OUT(BUZZER_OUT)
  );

  always #5 clk = ~clk;

  // Per-cycle stimulus of the current scenario (index = sampling edge number).
  bit en_a [CH][N];
  bit rst_a[N];
  int md_a [CH][N], don_a[CH][N], doff_a[CH][N], div_a[CH][N], nb_a[CH][N];
  // Expected per-channel behaviour per cycle.
  bit act_x[CH][N], tone_x[CH][N], done_x[CH][N];

  typedef struct {
    logic [CH-1:0] act;
    logic [CH-1:0] done;
    logic          ba;
    logic [1:0]    gi;
    logic          bz;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0;
  bit prev_wt = 0;

  task automatic check(string nm, int n, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, n, act, req);
    end
  endtask

  function automatic int max1(int x);
    return (x == 0) ? 1 : x;
  endfunction

  function automatic void set_cfg(int ch, int from, int md, int don, int doff, int dv, int nb);
    for (int c = from; c < N; c++) begin
      md_a[ch][c] = md; don_a[ch][c] = don; doff_a[ch][c] = doff;
      div_a[ch][c] = dv; nb_a[ch][c] = nb;
    end
  endfunction

  function automatic void set_en(int ch, int from, int to);
    for (int c = from; c < to && c < N; c++) en_a[ch][c] = 1'b1;
  endfunction

  function automatic void build_scen(int sid);
    for (int c = 0; c < N; c++) begin
      rst_a[c] = (c < 2);
      for (int ch = 0; ch < CH; ch++) en_a[ch][c] = 1'b0;
    end
    for (int ch = 0; ch < CH; ch++) set_cfg(ch, 0, 0, 1, 1, 0, 1);
    case (sid)
      0: begin set_cfg(0, 0, 0, 5, 3, 0, 1); set_en(0, 5, 25); end
      1: begin set_cfg(1, 0, 1, 3, 2, 0, 1); set_en(1, 5, 17); set_en(1, 40, 42); end
      2: begin
        set_cfg(2, 0, 3, 4, 4, 0, 3); set_en(2, 5, 60);
        set_cfg(2, 62, 3, 4, 4, 0, 0); set_en(2, 70, 100);
      end
      3: begin
        set_cfg(0, 0, 2, 1, 1, 2, 1); set_cfg(3, 0, 2, 1, 1, 0, 1);
        set_en(0, 5, 40); set_en(3, 5, 80);
      end
      4: begin set_cfg(2, 0, 3, 4, 4, 1, 3); set_en(2, 5, 200); rst_a[20] = 1'b1; end
      5: begin
        set_cfg(0, 0, 0, 5, 2, 1, 1); set_cfg(0, 7, 0, 9, 2, 1, 1);
        set_en(0, 5, 20); set_en(0, 30, 50);
      end
      default: begin
        for (int ch = 0; ch < CH; ch++) begin
          bit lvl = 0;
          set_cfg(ch, 0, $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 5),
                  $urandom_range(0, 3), $urandom_range(0, 4));
          for (int c = 2; c < N; c++) begin
            if ($urandom_range(0, 9) == 0) lvl = !lvl;
            en_a[ch][c] = lvl;
            if ($urandom_range(0, 29) == 0)
              set_cfg(ch, c, $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 5),
                      $urandom_range(0, 3), $urandom_range(0, 4));
          end
        end
        for (int c = 10; c < N; c++) if ($urandom_range(0, 199) == 0) rst_a[c] = 1'b1;
      end
    endcase
  endfunction

  // First edge at or after 'from' where enable is low (or e if none).
  function automatic int first_low(int ch, int from, int e);
    int j = from;
    while (j < e && en_a[ch][j]) j++;
    return j;
  endfunction

  // An ON interval starting at st, len cycles, cut off at lim; tone is a square of period 2*(dv+1).
  function automatic void on_seg(int ch, int st, int len, int dv, int lim);
    for (int c = st; c < st + len && c < lim; c++) begin
      act_x[ch][c]  = 1'b1;
      tone_x[ch][c] = (dv == 0) || (((c - st) / (dv + 1)) % 2 == 0);
    end
  endfunction

  // Channel timeline between resets: edges s..e-1, channel idle before edge s.
  function automatic void model_seg(int ch, int s, int e);
    int k = s;
    int st, j, h, t, md, dn, df, dv, nb;
    while (k < e) begin
      while (k < e && !en_a[ch][k]) k++;
      if (k >= e) break;
      st = k;
      md = md_a[ch][st]; dn = max1(don_a[ch][st]); df = max1(doff_a[ch][st]);
      dv = div_a[ch][st]; nb = max1(nb_a[ch][st]);
      case (md)
        0: begin
          on_seg(ch, st, dn, dv, e);
          h = st + dn;
          if (h < e) done_x[ch][h] = 1'b1;
          k = first_low(ch, h + 1, e) + 1;
        end
        1: begin
          t = st;
          while (1) begin
            on_seg(ch, t, dn, dv, e);
            t = t + dn + df;
            if (t >= e || !en_a[ch][t]) break;
          end
          k = t + 1;
        end
        2: begin
          j = first_low(ch, st + 1, e);
          on_seg(ch, st, j - st, dv, j);
          k = j + 1;
        end
        default: begin
          j = first_low(ch, st + 1, e);
          h = st + nb * (dn + df);
          for (int p = 0; p < nb; p++) on_seg(ch, st + p * (dn + df), dn, dv, j);
          if (j > h && h < e) done_x[ch][h] = 1'b1;
          k = j + 1;
        end
      endcase
    end
  endfunction

  function automatic void run_model();
    int s = 0;
    for (int c = 0; c < N; c++)
      for (int ch = 0; ch < CH; ch++) begin
        act_x[ch][c] = 0; tone_x[ch][c] = 0; done_x[ch][c] = 0;
      end
    for (int c = 0; c <= N; c++) begin
      if (c == N || rst_a[c]) begin
        if (c > s) for (int ch = 0; ch < CH; ch++) model_seg(ch, s, c);
        s = c + 1;
      end
    end
  endfunction

  task automatic drive_scen(int sid);
    exp_t e;
    bit   wt, found;
    build_scen(sid);
    run_model();
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      resetn = !rst_a[k];
      for (int i = 0; i < CH; i++) begin
        enable[i] = en_a[i][k];
        mode[2*i +: 2] = 2'(md_a[i][k]);
        duration_on[CNT_W*i +: CNT_W]  = CNT_W'(don_a[i][k]);
        duration_off[CNT_W*i +: CNT_W] = CNT_W'(doff_a[i][k]);
        tone_div[TONE_W*i +: TONE_W]   = TONE_W'(div_a[i][k]);
        burst_count[BURST_W*i +: BURST_W] = BURST_W'(nb_a[i][k]);
      end
      e.gi = 0; wt = 0; found = 0;
      for (int i = 0; i < CH; i++) begin
        e.act[i]  = act_x[i][k];
        e.done[i] = done_x[i][k];
        if (act_x[i][k] && !found) begin
          found = 1; e.gi = 2'(i); wt = tone_x[i][k];
        end
      end
      e.ba = found;
      e.bz = rst_a[k] ? 1'b0 : prev_wt;
      prev_wt = wt;
      exp_q.push_back(e);
    end
  endtask

  task automatic monitor();
    exp_t e;
    int bz_hi = 0, done0 = 0, done2 = 0, rise1 = 0, rise2 = 0;
    logic [CH-1:0] prev_act = '0;
    for (int n = 0; n < NSCEN * N; n++) begin
      int sid = n / N;
      int c   = n % N;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check("queue_empty", n, 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("ch_active", n, int'(ch_active), int'(e.act));
        check("ch_done", n, int'(ch_done), int'(e.done));
        check("buzzer_active", n, int'(buzzer_active), int'(e.ba));
        check("grant_idx", n, int'(grant_idx), int'(e.gi));
        check("BUZZER_OUT", n, int'(BUZZER_OUT), int'(e.bz));
      end
      if (c == 0) begin
        bz_hi = 0; done0 = 0; done2 = 0; rise1 = 0; rise2 = 0;
      end
      bz_hi += int'(BUZZER_OUT);
      done0 += int'(ch_done[0]);
      done2 += int'(ch_done[2]);
      rise1 += int'(ch_active[1] && !prev_act[1]);
      rise2 += int'(ch_active[2] && !prev_act[2]);
      prev_act = ch_active;
      if (c == N - 1) begin
        case (sid)
          0: begin
            check("t1_buzz_high_cycles", n, bz_hi, 5);
            check("t1_done_pulses", n, done0, 1);
          end
          1: check("t2_on_pulses", n, rise1, 4);
          2: begin
            check("t3_on_pulses", n, rise2, 4);
            check("t3_done_pulses", n, done2, 2);
          end
          4: begin
            check("t5_on_pulses", n, rise2, 5);
            check("t5_done_pulses", n, done2, 1);
          end
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    resetn = 1'b0; enable = '0; mode = '0; duration_on = '0; duration_off = '0;
    tone_div = '0; burst_count = '0;
    fork
      begin
        for (int s = 0; s < NSCEN; s++) drive_scen(s);
      end
      monitor();
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
